// File: rtl/oam_dma_if.sv
// oam_dma_if: groups the sprite-DMA trigger, the CPU-memory read port, the
// CPU-side PPU register access, the PPU register port and the status outputs.
// The master modport is the DMA engine. The slave modport is its surroundings.
// Optional signal dma_sum exists only when OAM_DMA_CHECKSUM_EN is defined.
interface oam_dma_if;
  logic        trig;
  logic [7:0]  trig_page;
  logic [2:0]  cpu_ppu_address;
  logic [7:0]  cpu_ppu_wdata;
  logic        cpu_ppu_rw;
  logic        cpu_ppu_cs;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [2:0]  ppu_address;
  logic [7:0]  ppu_wdata;
  logic        ppu_rw;
  logic        ppu_cs;
  logic        cpu_halt;
  logic        busy;
  logic        done;
`ifdef OAM_DMA_CHECKSUM_EN
  logic [7:0]  dma_sum;

  modport master (
    input  trig, trig_page, cpu_ppu_address, cpu_ppu_wdata, cpu_ppu_rw, cpu_ppu_cs, mem_rdata,
    output mem_addr, mem_rd, ppu_address, ppu_wdata, ppu_rw, ppu_cs, cpu_halt, busy, done, dma_sum
  );
  modport slave (
    output trig, trig_page, cpu_ppu_address, cpu_ppu_wdata, cpu_ppu_rw, cpu_ppu_cs, mem_rdata,
    input  mem_addr, mem_rd, ppu_address, ppu_wdata, ppu_rw, ppu_cs, cpu_halt, busy, done, dma_sum
  );
`else
  modport master (
    input  trig, trig_page, cpu_ppu_address, cpu_ppu_wdata, cpu_ppu_rw, cpu_ppu_cs, mem_rdata,
    output mem_addr, mem_rd, ppu_address, ppu_wdata, ppu_rw, ppu_cs, cpu_halt, busy, done
  );
  modport slave (
    output trig, trig_page, cpu_ppu_address, cpu_ppu_wdata, cpu_ppu_rw, cpu_ppu_cs, mem_rdata,
    input  mem_addr, mem_rd, ppu_address, ppu_wdata, ppu_rw, ppu_cs, cpu_halt, busy, done
  );
`endif
endinterface

// File: rtl/oam_dma.sv
// oam_dma: sprite-DMA engine. A $4014 write (trig) copies one CPU memory page
// into PPU OAM by repeated OAMDATA writes. The CPU is halted during the copy.
// Reads happen only on get cycles (parity 0). Writes happen on put cycles.
// When idle, CPU accesses to the PPU registers pass straight through.
// Optional feature macro: OAM_DMA_CHECKSUM_EN adds dma_sum, the modulo-256 sum
// of the bytes written during the current transfer.
module oam_dma #(
  parameter int unsigned XFER_LEN    = 256,
  parameter logic [2:0]  OAMDATA_REG = 3'd4
) (
  input  logic      clk,
  input  logic      rst_n,
  oam_dma_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  // The transfer length is a power of two no larger than 256.
  // The index therefore never needs more than 8 bits.
  // The low address byte never carries into the page.
  localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 32'd1);

  state_e     state_q, state_d;
  logic       parity_q;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic       done_q, done_d;

  // Free-running get/put parity: 0 = get cycle, 1 = put cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
    end
  end

  // Transfer state, byte index, source page and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      page_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. A trigger is accepted only in IDLE, so a trigger that
  // arrives while a copy is running is dropped rather than queued.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.trig) begin
          page_d  = bus.trig_page;
          idx_d   = 8'd0;
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        // parity_q=1 now means the next cycle is a get cycle.
        if (parity_q) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory read port and status outputs, decoded from the registered state.
  always_comb begin
    bus.mem_addr = {page_q, idx_q};
    bus.mem_rd   = (state_q == ST_READ);
    bus.cpu_halt = (state_q != ST_IDLE);
    bus.busy     = (state_q != ST_IDLE);
    bus.done     = done_q;
  end

  // PPU port multiplexer. The port passes CPU accesses through in IDLE and HALT.
  // It is quiet in ALIGN and READ. It writes OAMDATA in WRITE.
  always_comb begin
    bus.ppu_address = bus.cpu_ppu_address;
    bus.ppu_wdata   = bus.cpu_ppu_wdata;
    bus.ppu_rw      = bus.cpu_ppu_rw;
    bus.ppu_cs      = bus.cpu_ppu_cs;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        bus.ppu_address = bus.cpu_ppu_address;
        bus.ppu_wdata   = bus.cpu_ppu_wdata;
        bus.ppu_rw      = bus.cpu_ppu_rw;
        bus.ppu_cs      = bus.cpu_ppu_cs;
      end
      ST_WRITE: begin
        bus.ppu_address = OAMDATA_REG;
        bus.ppu_wdata   = bus.mem_rdata;
        bus.ppu_rw      = 1'b0;
        bus.ppu_cs      = 1'b1;
      end
      default: begin
        bus.ppu_address = 3'd0;
        bus.ppu_wdata   = 8'd0;
        bus.ppu_rw      = 1'b1;
        bus.ppu_cs      = 1'b0;
      end
    endcase
  end

`ifdef OAM_DMA_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  // Checksum update. The sum clears when a trigger is accepted. Each OAMDATA
  // byte is added as it is written. After the copy, the sum holds its value.
  always_comb begin
    sum_d = sum_q;
    if ((state_q == ST_IDLE) && bus.trig) begin
      sum_d = 8'd0;
    end else if (state_q == ST_WRITE) begin
      sum_d = sum_q + bus.mem_rdata;
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign bus.dma_sum = sum_q;
`endif

endmodule
